// File: rtl/passage_seq_ctrl.sv
// Two-sensor passage sequencer: debounces the raw A/B sensor pins, follows the
// order in which the beams are broken (A then B = entry, B then A = exit) and
// keeps a bounded occupancy count with one-cycle inc/dec/err strobes.
module passage_seq_ctrl #(
    parameter int DEB_CYC     = 8,
    parameter int TIMEOUT_CYC = 300,
    parameter int MAX_OCC     = 9,
    parameter int CW          = 4
) (
    input  logic          clkin,
    input  logic          rst,
    input  logic          Ain,
    input  logic          Bin,
    output logic          A,
    output logic          B,
    output logic          inc_pulse,
    output logic          dec_pulse,
    output logic [CW-1:0] occ,
    output logic          full,
    output logic          err,
    output logic [2:0]    state
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] OCC_MAX  = CW'(MAX_OCC);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        WCLR = 3'd7
    } st_t;

    // Channel 0 is sensor A, channel 1 is sensor B.
    logic [1:0]    raw;
    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [1:0]    deb;
    logic [DW-1:0] deb_cnt [2];

    st_t           st;
    logic [TW-1:0] tcnt;
    logic          a;
    logic          b;

    assign raw   = {Bin, Ain};
    assign a     = deb[0];
    assign b     = deb[1];
    assign A     = deb[0];
    assign B     = deb[1];
    assign state = st;

    // Two-flop synchronizer, then a per-channel run-length filter: the output
    // only flips after DEB_CYC consecutive samples disagree with it.
    always_ff @(posedge clkin) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Passage FSM with timeout, occupancy counter and registered strobes.
    // Each EN*/EX* state encodes the A/B pattern it expects; a change of both
    // bits at once is an illegal jump, and the timeout wins over any move.
    always_ff @(posedge clkin) begin
        if (!rst) begin
            st        <= IDLE;
            tcnt      <= '0;
            occ       <= '0;
            full      <= 1'b0;
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            err       <= 1'b0;
        end else begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
            err       <= 1'b0;
            if (st == IDLE) begin
                tcnt <= '0;
                if (a && b) begin
                    st  <= WCLR;
                    err <= 1'b1;
                end else if (a) begin
                    st <= EN1;
                end else if (b) begin
                    st <= EX1;
                end
            end else if (st == WCLR) begin
                tcnt <= '0;
                if (!a && !b) begin
                    st <= IDLE;
                end
            end else if (tcnt == TO_LAST) begin
                st   <= WCLR;
                err  <= 1'b1;
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
                case (st)
                    EN1: begin
                        if (!a && b) begin
                            st  <= WCLR;
                            err <= 1'b1;
                        end else if (b) begin
                            st <= EN2;
                        end else if (!a) begin
                            st <= IDLE;
                        end
                    end
                    EN2: begin
                        if (!a && !b) begin
                            st  <= WCLR;
                            err <= 1'b1;
                        end else if (!a) begin
                            st <= EN3;
                        end else if (!b) begin
                            st <= EN1;
                        end
                    end
                    EN3: begin
                        if (a && !b) begin
                            st  <= WCLR;
                            err <= 1'b1;
                        end else if (a) begin
                            st <= EN2;
                        end else if (!b) begin
                            st <= IDLE;
                            if (occ == OCC_MAX) begin
                                err <= 1'b1;
                            end else begin
                                occ       <= occ + CW'(1);
                                full      <= ((occ + CW'(1)) == OCC_MAX);
                                inc_pulse <= 1'b1;
                            end
                        end
                    end
                    EX1: begin
                        if (a && !b) begin
                            st  <= WCLR;
                            err <= 1'b1;
                        end else if (a) begin
                            st <= EX2;
                        end else if (!b) begin
                            st <= IDLE;
                        end
                    end
                    EX2: begin
                        if (!a && !b) begin
                            st  <= WCLR;
                            err <= 1'b1;
                        end else if (!b) begin
                            st <= EX3;
                        end else if (!a) begin
                            st <= EX1;
                        end
                    end
                    EX3: begin
                        if (!a && b) begin
                            st  <= WCLR;
                            err <= 1'b1;
                        end else if (b) begin
                            st <= EX2;
                        end else if (!a) begin
                            st <= IDLE;
                            if (occ == '0) begin
                                err <= 1'b1;
                            end else begin
                                occ       <= occ - CW'(1);
                                full      <= 1'b0;
                                dec_pulse <= 1'b1;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_passage_seq_ctrl.sv
// Bench for passage_seq_ctrl: directed vector table, hand-written corner
// sequences and randomized sensor traffic checked every cycle against a
// pattern-based reference model.
module tb_passage_seq_ctrl;

    localparam int DEB  = 8;
    localparam int TO   = 300;
    localparam int MAXO = 9;
    localparam int CW   = 4;

    logic          clkin = 1'b0;
    logic          rst   = 1'b0;
    logic          Ain   = 1'b0;
    logic          Bin   = 1'b0;
    logic          A, B, inc_pulse, dec_pulse, full, err;
    logic [CW-1:0] occ;
    logic [2:0]    state;

    int n_tests = 0;
    int n_fail  = 0;
    int inc_seen, dec_seen, err_seen;

    passage_seq_ctrl #(
        .DEB_CYC(DEB), .TIMEOUT_CYC(TO), .MAX_OCC(MAXO), .CW(CW)
    ) dut (
        .clkin(clkin), .rst(rst), .Ain(Ain), .Bin(Bin),
        .A(A), .B(B), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .occ(occ), .full(full), .err(err), .state(state)
    );

    always #5 clkin = ~clkin;

    // ---------------- reference model ----------------
    // Debounce: a sample reaches the filter two edges after capture; the output
    // flips once the last DEB filter samples all disagree with it.
    // Sequencing: tracked as a direction (entry/exit) plus the last legal A/B
    // pattern; the state code is derived from the direction and the pattern.
    bit        m_dly [2][2];
    bit        m_win [2][DEB];
    bit        m_deb [2];
    int        m_mode;          // 0 idle, 1 entry, 2 exit, 3 wait-clear
    bit [1:0]  m_pat;           // {A,B} of the current passage step
    int        m_enter;
    int        m_t;
    int        m_occ;
    bit        m_inc, m_dec, m_err;

    function automatic int phase_of(int mode, bit [1:0] p);
        if (p == 2'b11) return 2;
        if (mode == 1) return (p == 2'b10) ? 1 : 3;
        return (p == 2'b01) ? 1 : 3;
    endfunction

    function automatic int m_state();
        if (m_mode == 0) return 0;
        if (m_mode == 3) return 7;
        return (m_mode == 1 ? 0 : 3) + phase_of(m_mode, m_pat);
    endfunction

    always @(posedge clkin) begin : model
        bit [1:0] nw;
        bit       s2;
        bit       all_diff;
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                m_dly[c][0] = 0;
                m_dly[c][1] = 0;
                m_deb[c]    = 0;
                for (int k = 0; k < DEB; k++) m_win[c][k] = 0;
            end
            m_mode = 0; m_pat = 0; m_occ = 0;
            m_inc = 0; m_dec = 0; m_err = 0;
        end else begin
            m_inc = 0; m_dec = 0; m_err = 0;
            nw = {m_deb[0], m_deb[1]};
            if (m_mode == 0) begin
                if (nw == 2'b11) begin
                    m_mode = 3; m_err = 1;
                end else if (nw != 2'b00) begin
                    m_mode = nw[1] ? 1 : 2; m_pat = nw; m_enter = m_t;
                end
            end else if (m_mode == 3) begin
                if (nw == 2'b00) m_mode = 0;
            end else if (m_t - m_enter >= TO) begin
                m_mode = 3; m_err = 1;
            end else if ((nw ^ m_pat) == 2'b11) begin
                m_mode = 3; m_err = 1;
            end else if (nw != m_pat) begin
                if (nw == 2'b00) begin
                    if (phase_of(m_mode, m_pat) == 3) begin
                        if (m_mode == 1) begin
                            if (m_occ < MAXO) begin m_occ++; m_inc = 1; end
                            else m_err = 1;
                        end else begin
                            if (m_occ > 0) begin m_occ--; m_dec = 1; end
                            else m_err = 1;
                        end
                    end
                    m_mode = 0;
                end else begin
                    m_pat = nw;
                end
            end
            for (int c = 0; c < 2; c++) begin
                s2 = m_dly[c][0];
                m_dly[c][0] = m_dly[c][1];
                m_dly[c][1] = (c == 0) ? Ain : Bin;
                for (int k = 0; k < DEB - 1; k++) m_win[c][k] = m_win[c][k+1];
                m_win[c][DEB-1] = s2;
                all_diff = 1;
                for (int k = 0; k < DEB; k++) if (m_win[c][k] == m_deb[c]) all_diff = 0;
                if (all_diff) m_deb[c] = !m_deb[c];
            end
        end
        m_t++;
    end

    // ---------------- checking helpers ----------------
    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [12:0] got, exp;
        got = {A, B, inc_pulse, dec_pulse, occ, full, err, state};
        exp = {m_deb[0], m_deb[1], m_inc, m_dec, CW'(m_occ), (m_occ == MAXO),
               m_err, 3'(m_state())};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got %h, expected %h", $time, got, exp);
        end
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clkin);
            cmp_model();
            if (inc_pulse) inc_seen++;
            if (dec_pulse) dec_seen++;
            if (err) err_seen++;
        end
    endtask

    task automatic clear_seen();
        inc_seen = 0; dec_seen = 0; err_seen = 0;
    endtask

    task automatic drive_step(bit a, bit b, int n);
        Ain = a; Bin = b;
        step(n);
    endtask

    task automatic do_entry();
        drive_step(1, 0, 20);
        drive_step(1, 1, 20);
        drive_step(0, 1, 20);
        drive_step(0, 0, 20);
    endtask

    typedef struct {
        bit a; bit b; int hold;
        int st; int occ; int inc; int dec; int err;
    } vec_t;

    vec_t vt [18];

    initial begin
        vt[0]  = '{1, 0, 20,  1, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 20,  2, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 20,  3, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 20,  0, 1, 1, 0, 0};
        vt[4]  = '{0, 1, 20,  4, 1, 0, 0, 0};
        vt[5]  = '{1, 1, 20,  5, 1, 0, 0, 0};
        vt[6]  = '{1, 0, 20,  6, 1, 0, 0, 0};
        vt[7]  = '{0, 0, 20,  0, 0, 0, 1, 0};
        vt[8]  = '{0, 1, 20,  4, 0, 0, 0, 0};
        vt[9]  = '{1, 1, 20,  5, 0, 0, 0, 0};
        vt[10] = '{1, 0, 20,  6, 0, 0, 0, 0};
        vt[11] = '{0, 0, 20,  0, 0, 0, 0, 1};
        vt[12] = '{1, 0, 20,  1, 0, 0, 0, 0};
        vt[13] = '{0, 0, 20,  0, 0, 0, 0, 0};
        vt[14] = '{1, 1, 20,  7, 0, 0, 0, 1};
        vt[15] = '{0, 0, 20,  0, 0, 0, 0, 0};
        vt[16] = '{1, 0, 320, 7, 0, 0, 0, 1};
        vt[17] = '{0, 0, 20,  0, 0, 0, 0, 0};

        // Reset for one cycle, then everything must read zero.
        @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);
        rst = 1'b1;
        check("reset_outputs", int'({A, B, inc_pulse, dec_pulse, occ, full, err}), 0);
        check("reset_state", int'(state), 0);

        // Vector table: entry, exit, exit at zero, abort, collision, timeout.
        for (int v = 0; v < 18; v++) begin
            clear_seen();
            drive_step(vt[v].a, vt[v].b, vt[v].hold);
            check($sformatf("vec%0d_state", v), int'(state), vt[v].st);
            check($sformatf("vec%0d_occ", v), int'(occ), vt[v].occ);
            check($sformatf("vec%0d_inc", v), inc_seen, vt[v].inc);
            check($sformatf("vec%0d_dec", v), dec_seen, vt[v].dec);
            check($sformatf("vec%0d_err", v), err_seen, vt[v].err);
            check($sformatf("vec%0d_ab", v), int'({A, B}), int'({vt[v].a, vt[v].b}));
        end

        // Bouncing A for 10 cycles must not reach the output; a clean high
        // then appears exactly 2+DEB cycles after its capture edge.
        for (int i = 0; i < 10; i++) begin
            Ain = (i % 2 == 0);
            step(1);
            check("glitch_A_low", int'(A), 0);
        end
        Ain = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step(1);
            check($sformatf("deb_latency_%0d", n), int'(A), (n >= 2 + DEB) ? 1 : 0);
        end
        clear_seen();
        drive_step(0, 0, 20);
        check("abort_after_glitch_err", err_seen, 0);
        check("abort_after_glitch_state", int'(state), 0);

        // Fill to the ceiling, then overflow.
        clear_seen();
        for (int k = 0; k < MAXO; k++) do_entry();
        check("fill_occ", int'(occ), MAXO);
        check("fill_full", int'(full), 1);
        check("fill_inc", inc_seen, MAXO);
        clear_seen();
        do_entry();
        check("ovf_occ", int'(occ), MAXO);
        check("ovf_err", err_seen, 1);
        check("ovf_inc", inc_seen, 0);

        // Reset while in EN2 discards the passage and the count.
        clear_seen();
        drive_step(1, 0, 20);
        drive_step(1, 1, 20);
        check("mid_en2_state", int'(state), 2);
        rst = 1'b0; Ain = 1'b0; Bin = 1'b0;
        step(1);
        rst = 1'b1;
        check("mid_rst_occ", int'(occ), 0);
        check("mid_rst_full", int'(full), 0);
        check("mid_rst_state", int'(state), 0);
        step(20);
        check("mid_rst_inc", inc_seen, 0);
        check("mid_rst_occ_after", int'(occ), 0);

        // Randomized traffic: structured passages with random phase lengths
        // (short phases act as glitches), free random patterns, rare resets.
        for (int s = 0; s < 400; s++) begin
            int r;
            r = $urandom_range(19, 0);
            if (r == 0) begin
                rst = 1'b0;
                step(1);
                rst = 1'b1;
            end else if (r < 12) begin
                bit dir;
                dir = 1'($urandom_range(1, 0));
                if (dir) begin
                    drive_step(1, 0, $urandom_range(30, 3));
                    drive_step(1, 1, $urandom_range(30, 3));
                    drive_step(0, 1, $urandom_range(30, 3));
                end else begin
                    drive_step(0, 1, $urandom_range(30, 3));
                    drive_step(1, 1, $urandom_range(30, 3));
                    drive_step(1, 0, $urandom_range(30, 3));
                end
                drive_step(0, 0, $urandom_range(30, 12));
            end else begin
                drive_step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                           $urandom_range(25, 1));
            end
        end
        drive_step(0, 0, 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
